fft_twiddle_scale: RTL and testbench
====================================

# fft_twiddle_scale

Twiddle-multiply and scale stage for the final radix-2 combine of the 32K FFT. It takes the bottom-half sub-FFT stream, fetches W_N^k from an external twiddle ROM and forms the complex product. It delivers the product sign-extended to data_width+2 bits as rr_scaled_shifted / ri_scaled_shifted, aligned with out_ena/out_sop, to the comb_final_fft_res stage directly downstream.

## Interface
- data_width, 16, bit width of the signed input real/imag samples
- twiddle_width, 16, bit width of the signed Q1.(twiddle_width-1) twiddle real/imag; +1.0 is coded as 2^(twiddle_width-1)-1
- transform_length, 32768, full FFT length N; one frame is N/2 samples
- log2_transform_length, 15, log2(N); the twiddle index is log2_transform_length-1 bits wide

Ports:
- clk_fft  in  1  sole clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_real  in  data_width  signed bottom-half FFT real sample
- in_imag  in  data_width  signed bottom-half FFT imag sample
- in_ena  in  1  input sample valid
- in_sop  in  1  first sample of a frame; qualified by in_ena
- tw_rom_addr  out  log2_transform_length-1  twiddle index k, registered
- tw_rom_real  in  twiddle_width  ROM real output; 2-cycle read latency
- tw_rom_imag  in  twiddle_width  ROM imag output; 2-cycle read latency
- rr_scaled_shifted  out  data_width+2  signed real product
- ri_scaled_shifted  out  data_width+2  signed imag product
- out_ena  out  1  product valid
- out_sop  out  1  product is sample k=0
- frame_done  out  1  one-cycle pulse with the out_ena of sample k=N/2-1
- frame_err  out  1  one-cycle pulse, aligned with out_ena, marking a frame restarted before completion

## Operation
- States: IDLE and RUN. Reset enters IDLE with k=0.
- Accepted sample:
  - In IDLE: in_ena & in_sop.
  - In RUN: any in_ena.
  - In IDLE, in_ena without in_sop is dropped; it produces no out_ena and k does not change.
- Index k (log2_transform_length-1 bits) selects the twiddle for the current accepted sample.
  - Set to 0 when the accepted sample carries in_sop; otherwise it is the previous k+1.
  - On the accept of k=N/2-1, the state goes to IDLE and the frame_done tag is set.
  - The next frame needs a new sop.
- A RUN sample with in_sop and previous k≠N/2-1 restarts the frame at k=0 and carries the frame_err tag. The partial frame's outputs are already emitted and are not retracted.
- tw_rom_addr is registered with the k of each accepted sample and holds its value between accepts.
- Arithmetic, with br/bi = input and wr/wi = twiddle, all signed:
  - Real sum = br*wr − bi*wi; imag sum = br*wi + bi*wr. Products are data_width+twiddle_width bits and sums are +1 bit.
  - Rounding: add 2^(twiddle_width-2), then arithmetic right shift by twiddle_width-1.
  - The result fits data_width+2 bits with no saturation. Take the low data_width+2 bits.
- valid, sop, done and err tags travel down the pipeline with each accepted sample. Pipeline registers advance every cycle; there is no backpressure.

## Timing
- A sample accepted at edge E is seen in the stages as follows:
  - tw_rom_addr is valid after E+1.
  - ROM data is valid after E+3.
  - Products are registered at E+4.
  - The rounded result is registered at E+5.
- Outputs are valid for the cycle after E+5. Fixed latency is 5 cycles, independent of gaps.
- out_ena replicates the accepted-sample pattern delayed 5 cycles. Output data holds its last value when out_ena is low.
- Reset values: tw_rom_addr, rr/ri_scaled_shifted, out_ena, out_sop, frame_done and frame_err all 0; state IDLE; pipeline tags cleared.
- Reset asserted mid-frame:
  - Outputs go to 0 immediately and in-flight samples are discarded.
  - After release, nothing is emitted until a new sop.
- The same sample can carry both in_sop and k=N/2-1 only if N/2=1. This case is not supported.

## Test plan
- Reset hold: drive in_ena=1 random data with reset_n=0 → every output stays 0. After release, in_ena without sop → out_ena never rises.
- Identity twiddle: sop with in=(1000,0), ROM at k=0 returns (32767,0) → 5 cycles later out_sop=out_ena=1, rr=1000, ri=0, tw_rom_addr=0.
- Quarter twiddle: frame reaches k=8192, in=(1000,500), ROM (0,−32768) → tw_rom_addr=8192, output (500,−1000).
- Width headroom: in=(−32768,−32768), ROM (−32768,−32768) → rr=0, ri=65536 with no wrap in 18 bits.
- Gapped input: in_ena pattern 1,0,0,1,1,0,1 after sop → tw_rom_addr steps 0,1,2,3. The out_ena pattern is identical, shifted 5 cycles.
- Frame control:
  - A full frame of 16384 samples → frame_done pulses with the k=16383 output, the state returns to IDLE, and a trailing in_ena is ignored.
  - A sop at k=100 → frame_err pulses with that output, out_sop=1, and k restarts at 0.

Source files
------------

// File: rtl/fft_twiddle_scale_if.sv
// Bundles the sample stream, the twiddle ROM port and the product stream of
// fft_twiddle_scale.
//
// Handshake: in_ena qualifies in_real/in_imag/in_sop for one clk_fft cycle.
// out_ena qualifies rr/ri_scaled_shifted, out_sop, frame_done and frame_err
// for one cycle. Neither side can stall the other, so there is no ready signal.
//
// Modports:
//   slave  - the twiddle stage: consumes samples and ROM data, drives the
//            ROM address and the products.
//   master - the environment: upstream sub-FFT, twiddle ROM and downstream
//            combine stage.
interface fft_twiddle_scale_if #(
    parameter int data_width            = 16,
    parameter int twiddle_width         = 16,
    parameter int log2_transform_length = 15
);
    logic signed [data_width-1:0]      in_real;
    logic signed [data_width-1:0]      in_imag;
    logic                              in_ena;
    logic                              in_sop;
    logic [log2_transform_length-2:0]  tw_rom_addr;
    logic signed [twiddle_width-1:0]   tw_rom_real;
    logic signed [twiddle_width-1:0]   tw_rom_imag;
    logic signed [data_width+1:0]      rr_scaled_shifted;
    logic signed [data_width+1:0]      ri_scaled_shifted;
    logic                              out_ena;
    logic                              out_sop;
    logic                              frame_done;
    logic                              frame_err;

    modport slave (
        input  in_real, in_imag, in_ena, in_sop, tw_rom_real, tw_rom_imag,
        output tw_rom_addr, rr_scaled_shifted, ri_scaled_shifted,
               out_ena, out_sop, frame_done, frame_err
    );

    modport master (
        output in_real, in_imag, in_ena, in_sop, tw_rom_real, tw_rom_imag,
        input  tw_rom_addr, rr_scaled_shifted, ri_scaled_shifted,
               out_ena, out_sop, frame_done, frame_err
    );
endinterface

// File: rtl/fft_twiddle_scale.sv
// Twiddle-multiply and scale stage for the final radix-2 combine.
// The stage multiplies each bottom-half sample by W_N^k, which it reads from
// an external ROM with a 2-cycle read latency. It rounds the complex product
// and shifts it back to data_width+2 bits.
//
// Ports:
//   clk_fft     - sole clock, rising edge
//   reset_n     - asynchronous active-low reset
//   bus         - fft_twiddle_scale_if.slave: samples in, ROM address/data,
//                 products out with out_ena/out_sop/frame_done/frame_err
//   dbg_state_o - 1 while the frame FSM is in RUN, 0 in IDLE
//
// Pipeline: an accepted sample is registered at edge E (stage 0). The ROM
// address is registered at E+1. The ROM answers after E+3. The products are
// registered at E+4 and the rounded result at E+5. Latency is fixed at 5.
module fft_twiddle_scale #(
    parameter int data_width            = 16,
    parameter int twiddle_width         = 16,
    parameter int transform_length      = 32768,
    parameter int log2_transform_length = 15
) (
    input  logic               clk_fft,
    input  logic               reset_n,
    fft_twiddle_scale_if.slave bus,
    output logic               dbg_state_o
);
    localparam int KW = log2_transform_length - 1;
    localparam int PW = data_width + twiddle_width;
    localparam int SW = PW + 1;
    localparam int OW = data_width + 2;
    localparam int SH = twiddle_width - 1;
    localparam logic [KW-1:0]        K_LAST = KW'(transform_length / 2 - 1);
    localparam logic signed [SW-1:0] RND    = SW'(2 ** (twiddle_width - 2));

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          accept;
    logic          err_tag;
    logic          done_tag;

    // Tags: bit n is the tag of the sample registered n edges after acceptance.
    logic [4:0]    v_q, sop_q, done_q, err_q;
    logic [KW-1:0] k0_q;
    logic signed [data_width-1:0] d_re_q [4];
    logic signed [data_width-1:0] d_im_q [4];
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [SW-1:0] sum_r, sum_i;
    logic signed [OW-1:0] rr_d, ri_d;

    // In IDLE, only a sop opens a frame. In RUN, every in_ena is a sample,
    // and a sop restarts the index.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        accept   = 1'b0;
        err_tag  = 1'b0;
        done_tag = 1'b0;
        case (state_q)
            IDLE:    accept = bus.in_ena & bus.in_sop;
            RUN:     accept = bus.in_ena;
            default: accept = 1'b0;
        endcase
        if (accept) begin
            k_d      = bus.in_sop ? '0 : k_q + KW'(1);
            err_tag  = (state_q == RUN) && bus.in_sop && (k_q != K_LAST);
            done_tag = (k_d == K_LAST);
            state_d  = done_tag ? IDLE : RUN;
        end
    end

    // Round half up, then drop the Q1.(twiddle_width-1) fraction bits.
    always_comb begin
        sum_r = SW'(p_rr_q) - SW'(p_ii_q) + RND;
        sum_i = SW'(p_ri_q) + SW'(p_ir_q) + RND;
        rr_d  = OW'(sum_r >>> SH);
        ri_d  = OW'(sum_i >>> SH);
    end

    always_ff @(posedge clk_fft or negedge reset_n) begin
        if (!reset_n) begin
            state_q               <= IDLE;
            k_q                   <= '0;
            v_q                   <= '0;
            sop_q                 <= '0;
            done_q                <= '0;
            err_q                 <= '0;
            k0_q                  <= '0;
            d_re_q                <= '{default: '0};
            d_im_q                <= '{default: '0};
            p_rr_q                <= '0;
            p_ii_q                <= '0;
            p_ri_q                <= '0;
            p_ir_q                <= '0;
            bus.tw_rom_addr       <= '0;
            bus.rr_scaled_shifted <= '0;
            bus.ri_scaled_shifted <= '0;
            bus.out_ena           <= 1'b0;
            bus.out_sop           <= 1'b0;
            bus.frame_done        <= 1'b0;
            bus.frame_err         <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            v_q       <= {v_q[3:0], accept};
            sop_q     <= {sop_q[3:0], accept & bus.in_sop};
            done_q    <= {done_q[3:0], done_tag};
            err_q     <= {err_q[3:0], err_tag};
            k0_q      <= k_d;
            d_re_q[0] <= bus.in_real;
            d_im_q[0] <= bus.in_imag;
            for (int i = 1; i < 4; i++) begin
                d_re_q[i] <= d_re_q[i-1];
                d_im_q[i] <= d_im_q[i-1];
            end
            // The address only moves on accepted samples, so it holds across gaps.
            if (v_q[0]) begin
                bus.tw_rom_addr <= k0_q;
            end
            // Stage 3 data meets the ROM word for the same sample here.
            p_rr_q <= PW'(d_re_q[3]) * PW'(bus.tw_rom_real);
            p_ii_q <= PW'(d_im_q[3]) * PW'(bus.tw_rom_imag);
            p_ri_q <= PW'(d_re_q[3]) * PW'(bus.tw_rom_imag);
            p_ir_q <= PW'(d_im_q[3]) * PW'(bus.tw_rom_real);
            bus.out_ena    <= v_q[4];
            bus.out_sop    <= sop_q[4];
            bus.frame_done <= done_q[4];
            bus.frame_err  <= err_q[4];
            if (v_q[4]) begin
                bus.rr_scaled_shifted <= rr_d;
                bus.ri_scaled_shifted <= ri_d;
            end
        end
    end

    assign dbg_state_o = (state_q == RUN);
endmodule

// File: tb/tb_fft_twiddle_scale.sv
// Directed bench for fft_twiddle_scale. A behavioural twiddle ROM with a
// 2-cycle read latency answers the DUT. Inputs change 1 ns after the rising
// edge, and outputs are sampled at that same point.
module tb_fft_twiddle_scale;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic dbg_state;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fft_twiddle_scale_if #(.data_width(16), .twiddle_width(16), .log2_transform_length(15)) bus ();

    fft_twiddle_scale #(
        .data_width(16), .twiddle_width(16), .transform_length(32768), .log2_transform_length(15)
    ) dut (
        .clk_fft(clk), .reset_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
    );

    // Twiddle ROM model: k=0 -> +1.0, k=1 -> (-1,-1), k=8192 -> -j, else +0.5.
    function automatic logic [31:0] rom_lookup(input logic [13:0] a);
        case (a)
            14'd0:    return {16'h7FFF, 16'h0000};
            14'd1:    return {16'h8000, 16'h8000};
            14'd8192: return {16'h0000, 16'h8000};
            default:  return {16'h4000, 16'h0000};
        endcase
    endfunction

    logic signed [15:0] rom_re1, rom_im1, rom_re2, rom_im2;
    always @(posedge clk) begin
        {rom_re1, rom_im1} <= rom_lookup(bus.tw_rom_addr);
        rom_re2 <= rom_re1;
        rom_im2 <= rom_im1;
    end
    assign bus.tw_rom_real = rom_re2;
    assign bus.tw_rom_imag = rom_im2;

    task automatic drive(input logic ena, input logic sop, input int re, input int im);
        bus.in_ena  = ena;
        bus.in_sop  = sop;
        bus.in_real = 16'(re);
        bus.in_imag = 16'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        logic [3:0] flags;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 65535)));
            flags = {bus.out_ena, bus.out_sop, bus.frame_done, bus.frame_err};
            n_tests++;
            if (flags !== 4'b0 || bus.rr_scaled_shifted !== 18'd0 ||
                bus.ri_scaled_shifted !== 18'd0 || bus.tw_rom_addr !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_hold: flags=%b rr=%0d ri=%0d addr=%0d expected all 0",
                         flags, bus.rr_scaled_shifted, bus.ri_scaled_shifted, bus.tw_rom_addr);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, int'($urandom_range(0, 65535)), 5);
            n_tests++;
            if (bus.out_ena !== 1'b0 || dbg_state !== 1'b0) begin
                n_fail++;
                $display("FAIL no_sop_dropped: out_ena=%b state=%b expected 0 0", bus.out_ena, dbg_state);
            end
        end
    endtask

    task automatic test_identity();
        apply_reset();
        drive(1'b1, 1'b1, 1000, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            n_tests++;
            if (bus.out_ena !== 1'b0) begin
                n_fail++;
                $display("FAIL identity_early: out_ena=%b at cycle %0d expected 0", bus.out_ena, i + 1);
            end
        end
        idle(1);
        n_tests++;
        if (bus.out_ena !== 1'b1 || bus.out_sop !== 1'b1 || bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_tags: ena=%b sop=%b err=%b expected 1 1 0", bus.out_ena, bus.out_sop, bus.frame_err);
        end
        n_tests++;
        if (bus.rr_scaled_shifted !== 18'sd1000 || bus.ri_scaled_shifted !== 18'sd0) begin
            n_fail++;
            $display("FAIL identity_data: rr=%0d ri=%0d expected 1000 0", bus.rr_scaled_shifted, bus.ri_scaled_shifted);
        end
        n_tests++;
        if (bus.tw_rom_addr !== 14'd0) begin
            n_fail++;
            $display("FAIL identity_addr: addr=%0d expected 0", bus.tw_rom_addr);
        end
        idle(1);
        n_tests++;
        if (bus.out_ena !== 1'b0 || bus.rr_scaled_shifted !== 18'sd1000) begin
            n_fail++;
            $display("FAIL identity_hold: ena=%b rr=%0d expected 0 1000", bus.out_ena, bus.rr_scaled_shifted);
        end
    endtask

    // Continues the frame opened by test_identity: this sample is k=1.
    task automatic test_headroom();
        drive(1'b1, 1'b0, -32768, -32768);
        idle(1);
        n_tests++;
        if (bus.tw_rom_addr !== 14'd1) begin
            n_fail++;
            $display("FAIL headroom_addr: addr=%0d expected 1", bus.tw_rom_addr);
        end
        idle(4);
        n_tests++;
        if (bus.out_ena !== 1'b1 || bus.out_sop !== 1'b0 ||
            bus.rr_scaled_shifted !== 18'sd0 || bus.ri_scaled_shifted !== 18'sd65536) begin
            n_fail++;
            $display("FAIL headroom_data: ena=%b sop=%b rr=%0d ri=%0d expected 1 0 0 65536",
                     bus.out_ena, bus.out_sop, bus.rr_scaled_shifted, bus.ri_scaled_shifted);
        end
    endtask

    task automatic test_gapped();
        logic [6:0] pat = 7'b1011001;
        logic       exp_ena;
        int         k_cnt = 0;
        int         exp_addr = 0;
        int         prev_k = -1;
        apply_reset();
        for (int t = 0; t < 13; t++) begin
            logic ena;
            ena = (t < 7) ? pat[t] : 1'b0;
            drive(ena, t == 0, 100 + t, 0);
            if (prev_k >= 0) exp_addr = prev_k;
            prev_k = -1;
            if (ena) begin
                prev_k = k_cnt;
                k_cnt++;
            end
            n_tests++;
            if (bus.tw_rom_addr !== 14'(exp_addr)) begin
                n_fail++;
                $display("FAIL gapped_addr: step %0d addr=%0d expected %0d", t, bus.tw_rom_addr, exp_addr);
            end
            exp_ena = (t >= 5 && t < 12) ? pat[t-5] : 1'b0;
            n_tests++;
            if (bus.out_ena !== exp_ena || bus.out_sop !== (t == 5)) begin
                n_fail++;
                $display("FAIL gapped_ena: step %0d ena=%b sop=%b expected %b %b",
                         t, bus.out_ena, bus.out_sop, exp_ena, t == 5);
            end
        end
    endtask

    task automatic test_full_frame();
        int outs = 0;
        apply_reset();
        for (int i = 0; i < 16384 + 8 + 6; i++) begin
            if (i < 16384) drive(1'b1, i == 0, 1000, 500);
            else if (i < 16392) drive(1'b1, 1'b0, 7, 7);
            else idle(1);
            if (i == 8193) begin
                n_tests++;
                if (bus.tw_rom_addr !== 14'd8192) begin
                    n_fail++;
                    $display("FAIL quarter_addr: addr=%0d expected 8192", bus.tw_rom_addr);
                end
            end
            if (i == 16383) begin
                n_tests++;
                if (dbg_state !== 1'b0) begin
                    n_fail++;
                    $display("FAIL frame_idle: state=%b expected 0", dbg_state);
                end
            end
            n_tests++;
            if (bus.out_ena) begin
                if (bus.frame_done !== (outs == 16383) || bus.out_sop !== (outs == 0) || bus.frame_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL frame_tags: out %0d done=%b sop=%b err=%b", outs, bus.frame_done, bus.out_sop, bus.frame_err);
                end
                if (outs == 1 || outs == 2 || outs == 8192) begin
                    int er, ei;
                    er = (outs == 1) ? -500 : 500;
                    ei = (outs == 1) ? -1500 : ((outs == 2) ? 250 : -1000);
                    n_tests++;
                    if (bus.rr_scaled_shifted !== 18'(er) || bus.ri_scaled_shifted !== 18'(ei)) begin
                        n_fail++;
                        $display("FAIL frame_data: out %0d rr=%0d ri=%0d expected %0d %0d",
                                 outs, bus.rr_scaled_shifted, bus.ri_scaled_shifted, er, ei);
                    end
                end
                outs++;
            end else if (bus.frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_done_stray: done=%b without out_ena expected 0", bus.frame_done);
            end
        end
        n_tests++;
        if (outs != 16384) begin
            n_fail++;
            $display("FAIL frame_count: outputs=%0d expected 16384", outs);
        end
    endtask

    task automatic test_frame_err();
        int outs = 0;
        apply_reset();
        for (int i = 0; i < 109; i++) begin
            if (i < 100) drive(1'b1, i == 0, i, 0);
            else if (i == 100) drive(1'b1, 1'b1, 1000, 0);
            else if (i < 103) drive(1'b1, 1'b0, 3, 3);
            else idle(1);
            if (i == 101 || i == 102) begin
                n_tests++;
                if (bus.tw_rom_addr !== 14'(i - 101) || dbg_state !== 1'b1) begin
                    n_fail++;
                    $display("FAIL restart_addr: addr=%0d state=%b expected %0d 1", bus.tw_rom_addr, dbg_state, i - 101);
                end
            end
            if (bus.out_ena) begin
                n_tests++;
                if (bus.frame_err !== (outs == 100) || bus.out_sop !== (outs == 0 || outs == 100) ||
                    bus.frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL restart_tags: out %0d err=%b sop=%b done=%b", outs, bus.frame_err, bus.out_sop, bus.frame_done);
                end
                if (outs == 100) begin
                    n_tests++;
                    if (bus.rr_scaled_shifted !== 18'sd1000 || bus.ri_scaled_shifted !== 18'sd0) begin
                        n_fail++;
                        $display("FAIL restart_data: rr=%0d ri=%0d expected 1000 0", bus.rr_scaled_shifted, bus.ri_scaled_shifted);
                    end
                end
                outs++;
            end
        end
        n_tests++;
        if (outs != 103) begin
            n_fail++;
            $display("FAIL restart_count: outputs=%0d expected 103", outs);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        drive(1'b1, 1'b1, 1000, 0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1000, 0);
        n_tests++;
        if (bus.out_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: out_ena=%b expected 1", bus.out_ena);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_ena !== 1'b0 || bus.out_sop !== 1'b0 || bus.rr_scaled_shifted !== 18'd0 ||
            bus.tw_rom_addr !== 14'd0 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: ena=%b sop=%b rr=%0d addr=%0d state=%b expected all 0",
                     bus.out_ena, bus.out_sop, bus.rr_scaled_shifted, bus.tw_rom_addr, dbg_state);
        end
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 44, 44);
            n_tests++;
            if (bus.out_ena !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_flush: out_ena=%b at cycle %0d expected 0", bus.out_ena, i);
            end
        end
        drive(1'b1, 1'b1, 1000, 0);
        idle(5);
        n_tests++;
        if (bus.out_ena !== 1'b1 || bus.out_sop !== 1'b1 || bus.rr_scaled_shifted !== 18'sd1000) begin
            n_fail++;
            $display("FAIL midreset_resume: ena=%b sop=%b rr=%0d expected 1 1 1000",
                     bus.out_ena, bus.out_sop, bus.rr_scaled_shifted);
        end
    endtask

    initial begin
        bus.in_ena  = 1'b0;
        bus.in_sop  = 1'b0;
        bus.in_real = '0;
        bus.in_imag = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_identity();
        test_headroom();
        test_gapped();
        test_full_frame();
        test_frame_err();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
